hpi_access_arbiter: RTL and testbench

- Shares the CY7C67200 OTG HPI bus between two requesters: port 0 is the Nios-side PIO bridge, port 1 is the hardware keycode poller.
- Generates the HPI bus-cycle timing (address setup, strobe width, hold) from the 50 MHz system clock.
- Sits between the Nios system's HPI PIO exports and the top-level OTG pins, replacing direct PIO-driven bit-banging.

---
 rtl/hpi_arb_pkg.sv | 19 +
 rtl/hpi_rr_grant.sv | 33 +++
 rtl/hpi_access_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_hpi_access_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hpi_arb_pkg.sv
// Shared types and constants for the CY7C67200 HPI access arbiter.
//   hpi_state_e : bus-cycle timing states (IDLE, SETUP, STROBE, HOLD, DONE)
//   HPI_*       : HPI register addresses as presented on OTG_ADDR
package hpi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } hpi_state_e;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDR    = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

endpackage

// File: rtl/hpi_rr_grant.sv
// Two-way grant selection for the HPI arbiter.
// Configuration macro: HPI_ARB_RR_EN
//   defined   : round-robin, on contention the port that did not win last time wins
//   undefined : fixed priority, port 0 always wins (last_grant port is absent)
// Ports:
//   req0, req1  : requests from port 0 / port 1
//   last_grant  : port granted by the previous completed transaction (RR build only)
//   grant_valid : at least one request is pending
//   grant       : index of the winning port (0 or 1), meaningful when grant_valid
module hpi_rr_grant (
  input  logic req0,
  input  logic req1,
`ifdef HPI_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic grant_valid,
  output logic grant
);

  always_comb begin
    grant_valid = req0 | req1;
`ifdef HPI_ARB_RR_EN
    if (req0 && req1) begin
      grant = ~last_grant;
    end else begin
      grant = req1;
    end
`else
    grant = ~req0 & req1;
`endif
  end

endmodule

// File: rtl/hpi_access_arbiter.sv
// Shares the CY7C67200 HPI bus between the Nios PIO bridge (port 0) and the
// hardware keycode poller (port 1), and generates the HPI bus-cycle timing.
// Configuration macro: HPI_ARB_RR_EN (round-robin when defined, port 0 priority otherwise)
// Ports:
//   Clk, Reset                : 50 MHz clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN     : request, write enable, HPI address, write data per port
//   ackN/rdataN               : one-cycle completion pulse, read data (valid with ack)
//   hpi_addr/cs_n/r_n/w_n     : registered HPI control pins
//   hpi_dout/hpi_oe/hpi_din   : data pad output, output enable, sampled pad input
//   busy                      : transaction in progress (state not IDLE)
module hpi_access_arbiter
  import hpi_arb_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned CNT_W      = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [1:0]  addr0,
  input  logic [15:0] wdata0,
  output logic        ack0,
  output logic [15:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [1:0]  addr1,
  input  logic [15:0] wdata1,
  output logic        ack1,
  output logic [15:0] rdata1,
  output logic [1:0]  hpi_addr,
  output logic        hpi_cs_n,
  output logic        hpi_r_n,
  output logic        hpi_w_n,
  output logic [15:0] hpi_dout,
  output logic        hpi_oe,
  input  logic [15:0] hpi_din,
  output logic        busy
);

  // Counters count down to zero, so each phase lasts (load + 1) cycles.
  localparam logic [CNT_W-1:0] SetupLoad  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] StrobeLoad = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HoldLoad   = CNT_W'(HOLD_CYC - 1);

  hpi_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt_q, gnt_d;
  logic             we_q, we_d;
  logic [1:0]       addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [15:0]      rdata0_q, rdata0_d;
  logic [15:0]      rdata1_q, rdata1_d;
  logic             cs_n_q, cs_n_d;
  logic             r_n_q, r_n_d;
  logic             w_n_q, w_n_d;
  logic             oe_q, oe_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             on_bus;

  logic             grant_valid;
  logic             grant;

`ifdef HPI_ARB_RR_EN
  logic             last_grant_q, last_grant_d;

  hpi_rr_grant u_grant (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant       (grant)
  );
`else
  hpi_rr_grant u_grant (
    .req0        (req0),
    .req1        (req1),
    .grant_valid (grant_valid),
    .grant       (grant)
  );
`endif

  // Next-state, datapath latching and read capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef HPI_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          gnt_d   = grant;
          we_d    = grant ? we1    : we0;
          addr_d  = grant ? addr1  : addr0;
          wdata_d = grant ? wdata1 : wdata0;
          cnt_d   = SetupLoad;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = StrobeLoad;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          // Sample the pad on the last strobe-low cycle, where the chip's data is settled.
          if (!we_q) begin
            if (gnt_q) begin
              rdata1_d = hpi_din;
            end else begin
              rdata0_d = hpi_din;
            end
          end
          cnt_d   = HoldLoad;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
`ifdef HPI_ARB_RR_EN
        last_grant_d = gnt_q;
`endif
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pin values are decoded from the next state so the registered pins line up
  // with the state register rather than lagging it by a cycle.
  always_comb begin
    on_bus = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    cs_n_d = ~on_bus;
    oe_d   = on_bus & we_d;
    r_n_d  = ~((state_d == STROBE) & ~we_d);
    w_n_d  = ~((state_d == STROBE) & we_d);
    ack0_d = (state_d == DONE) & ~gnt_q;
    ack1_d = (state_d == DONE) & gnt_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 2'd0;
      wdata_q  <= 16'h0000;
      rdata0_q <= 16'h0000;
      rdata1_q <= 16'h0000;
      cs_n_q   <= 1'b1;
      r_n_q    <= 1'b1;
      w_n_q    <= 1'b1;
      oe_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cs_n_q   <= cs_n_d;
      r_n_q    <= r_n_d;
      w_n_q    <= w_n_d;
      oe_q     <= oe_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
    end
  end

`ifdef HPI_ARB_RR_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Address and write data come straight from the latched request registers.
  assign hpi_addr = addr_q;
  assign hpi_dout = wdata_q;
  assign hpi_cs_n = cs_n_q;
  assign hpi_r_n  = r_n_q;
  assign hpi_w_n  = w_n_q;
  assign hpi_oe   = oe_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_hpi_access_arbiter.sv
// Directed self-checking bench for hpi_access_arbiter: default-timing instance
// plus a 1/1/1-cycle instance for the single-cycle phase case.
module tb_hpi_access_arbiter;
  import hpi_arb_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [1:0]  addr0 = 2'd0, addr1 = 2'd0;
  logic [15:0] wdata0 = 16'h0, wdata1 = 16'h0, hpi_din = 16'h0;
  logic        ack0, ack1, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_oe, busy;
  logic [15:0] rdata0, rdata1, hpi_dout;
  logic [1:0]  hpi_addr;

  logic        f_req0 = 1'b0, f_we0 = 1'b0, f_req1 = 1'b0, f_we1 = 1'b0;
  logic [1:0]  f_addr0 = 2'd0, f_addr1 = 2'd0;
  logic [15:0] f_wdata0 = 16'h0, f_wdata1 = 16'h0, f_din = 16'h0;
  logic        f_ack0, f_ack1, f_cs_n, f_r_n, f_w_n, f_oe, f_busy;
  logic [15:0] f_rdata0, f_rdata1, f_dout;
  logic [1:0]  f_addr;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] m_rd0 = 16'h0, m_rd1 = 16'h0;

  always #5 Clk = ~Clk;

  hpi_access_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .hpi_addr(hpi_addr), .hpi_cs_n(hpi_cs_n), .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n),
    .hpi_dout(hpi_dout), .hpi_oe(hpi_oe), .hpi_din(hpi_din), .busy(busy)
  );

  hpi_access_arbiter #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .CNT_W(4)) dut_fast (
    .Clk(Clk), .Reset(Reset),
    .req0(f_req0), .we0(f_we0), .addr0(f_addr0), .wdata0(f_wdata0), .ack0(f_ack0),
    .rdata0(f_rdata0),
    .req1(f_req1), .we1(f_we1), .addr1(f_addr1), .wdata1(f_wdata1), .ack1(f_ack1),
    .rdata1(f_rdata1),
    .hpi_addr(f_addr), .hpi_cs_n(f_cs_n), .hpi_r_n(f_r_n), .hpi_w_n(f_w_n),
    .hpi_dout(f_dout), .hpi_oe(f_oe), .hpi_din(f_din), .busy(f_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction on the default-timing instance (2/4/2): grant in the cycle
  // the request is raised, cs_n low cycles 1..8, strobe low 3..6, ack at 9.
  // hpi_din carries junk early in STROBE and rd_val only on the last STROBE cycle.
  task automatic txn(input bit port, input logic we, input logic [1:0] addr,
                     input logic [15:0] wdata, input logic [15:0] rd_val,
                     input int drop_k, input string tag);
    int acks;
    logic [6:0] exp_v;
    logic [6:0] obs_v;
    acks = 0;
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    end
    for (int k = 1; k <= 10; k++) begin
      bit on_bus;
      bit strobe;
      @(negedge Clk);
      on_bus = (k >= 1) && (k <= 8);
      strobe = (k >= 3) && (k <= 6);
      exp_v = {!on_bus, !(strobe && !we), !(strobe && we), on_bus && we,
               (k == 9) && !port, (k == 9) && port, k <= 9};
      obs_v = {hpi_cs_n, hpi_r_n, hpi_w_n, hpi_oe, ack0, ack1, busy};
      chk($sformatf("%s pins k=%0d", tag, k), {25'd0, obs_v}, {25'd0, exp_v});
      if (k == 1 || k == 8) begin
        chk($sformatf("%s addr k=%0d", tag, k), {30'd0, hpi_addr}, {30'd0, addr});
        if (we) chk($sformatf("%s dout k=%0d", tag, k), {16'd0, hpi_dout}, {16'd0, wdata});
      end
      if (ack0 || ack1) acks++;
      if (k == 9 && !we) begin
        if (port) m_rd1 = rd_val;
        else m_rd0 = rd_val;
      end
      if (k >= 9) begin
        chk($sformatf("%s rdata0 k=%0d", tag, k), {16'd0, rdata0}, {16'd0, m_rd0});
        chk($sformatf("%s rdata1 k=%0d", tag, k), {16'd0, rdata1}, {16'd0, m_rd1});
      end
      hpi_din = (k >= 3 && k <= 5) ? 16'hDEAD : ((k == 6) ? rd_val : 16'h0000);
      if (k == drop_k || k == 9) begin
        if (port) req1 = 1'b0;
        else req0 = 1'b0;
      end
    end
    chk($sformatf("%s ack count", tag), acks, 1);
  endtask

  initial begin
    int acks, gap, pulse, cyc;
    bit seen_pulse;
    logic prev_cs;
    logic order [4];
    logic exp_order [4];

    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    chk("reset pins", {25'd0, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_oe, ack0, ack1, busy},
        {25'd0, 7'b1110000});
    chk("reset addr/dout", {14'd0, hpi_addr, hpi_dout}, 32'd0);
    chk("reset rdata", {rdata0, rdata1}, 32'd0);

    txn(1'b0, 1'b1, HPI_ADDR, 16'h1234, 16'h0000, 0, "wr0");
    txn(1'b1, 1'b0, HPI_DATA, 16'h5555, 16'hBEEF, 0, "rd1");

    // Contention: both held for four transactions.
    req0 = 1'b1; we0 = 1'b1; addr0 = HPI_MAILBOX; wdata0 = 16'hA0A0;
    req1 = 1'b1; we1 = 1'b1; addr1 = HPI_STATUS;  wdata1 = 16'hB1B1;
    acks = 0; gap = 0; pulse = 0; cyc = 0; seen_pulse = 1'b0; prev_cs = 1'b1;
    while (acks < 4 && cyc < 80) begin
      @(negedge Clk);
      cyc++;
      chk("arb dual ack", {31'd0, ack0 & ack1}, 32'd0);
      if (hpi_cs_n == 1'b0) begin
        if (prev_cs && seen_pulse) chk("arb idle gap", gap, 2);
        pulse++;
      end else begin
        if (!prev_cs) begin
          chk("arb cs_n width", pulse, 8);
          seen_pulse = 1'b1;
          gap = 0;
          pulse = 0;
        end
        gap++;
      end
      if (ack0 || ack1) begin
        order[acks] = ack1;
        chk($sformatf("arb addr %0d", acks), {30'd0, hpi_addr},
            {30'd0, ack1 ? HPI_STATUS : HPI_MAILBOX});
        acks++;
        if (acks == 4) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
      prev_cs = hpi_cs_n;
    end
    chk("arb ack total", acks, 4);
`ifdef HPI_ARB_RR_EN
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
`else
    exp_order[0] = 1'b0; exp_order[1] = 1'b0; exp_order[2] = 1'b0; exp_order[3] = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("arb order %0d", i), {31'd0, order[i]}, {31'd0, exp_order[i]});
    end
    @(negedge Clk);
    chk("arb idle after", {31'd0, busy}, 32'd0);

    // Request dropped at cycle 2; transaction still completes with one ack.
    txn(1'b0, 1'b0, HPI_DATA, 16'h0000, 16'h5A5A, 2, "rd0_drop");

    // Reset in the middle of a write strobe.
    req0 = 1'b1; we0 = 1'b1; addr0 = HPI_MAILBOX; wdata0 = 16'h7777;
    for (int k = 1; k <= 4; k++) @(negedge Clk);
    chk("rst pre w_n", {31'd0, hpi_w_n}, 32'd0);
    Reset = 1'b1;
    req0 = 1'b0;
    @(negedge Clk);
    chk("rst pins", {25'd0, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_oe, ack0, ack1, busy},
        {25'd0, 7'b1110000});
    chk("rst rdata", {rdata0, rdata1}, 32'd0);
    m_rd0 = 16'h0;
    m_rd1 = 16'h0;
    Reset = 1'b0;
    acks = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk);
      if (ack0 || ack1 || busy) acks++;
    end
    chk("rst no ack", acks, 0);
    txn(1'b1, 1'b0, HPI_ADDR, 16'h0000, 16'h4321, 0, "post_rst");

    // Single-cycle phases: cs_n low 1..3, r_n low at 2, ack at 4.
    f_req0 = 1'b1; f_we0 = 1'b0; f_addr0 = HPI_STATUS;
    acks = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      chk($sformatf("fast pins k=%0d", k),
          {25'd0, f_cs_n, f_r_n, f_w_n, f_oe, f_ack0, f_ack1, f_busy},
          {25'd0, !(k >= 1 && k <= 3), k != 2, 1'b1, 1'b0, k == 4, 1'b0, k <= 4});
      if (f_ack0 || f_ack1) acks++;
      if (k == 4) begin
        chk("fast rdata0", {16'd0, f_rdata0}, 32'h0000CAFE);
        f_req0 = 1'b0;
      end
      f_din = (k == 1) ? 16'h1111 : ((k == 2) ? 16'hCAFE : 16'h0000);
    end
    chk("fast ack count", acks, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
